sema_mailbox: RTL



---
 rtl/sema_pkg.sv | 16 +
 rtl/sema_fifo.sv | 78 +++++++
 rtl/sema_mailbox.sv | 54 +++++
 3 files changed

// File: rtl/sema_pkg.sv
// rtl/sema_pkg.sv - shared constants, types and sizing helper for the semaphore mailbox
package sema_pkg;

   localparam int SEMA_DEPTH_DEFAULT = 4;

   typedef enum logic {
      DIR_B2b = 1'b0,
      DIR_b2B = 1'b1
   } sema_dir_t;

   // Occupancy must represent 0..DEPTH inclusive, hence one bit beyond the pointer width.
   function automatic int sema_cnt_w(input int depth);
      return $clog2(depth) + 1;
   endfunction

endpackage

// File: rtl/sema_fifo.sv
// rtl/sema_fifo.sv - one-direction FIFO of 1-bit semaphore tokens with sticky overflow
module sema_fifo
   import sema_pkg::*;
#(
   parameter int DEPTH = SEMA_DEPTH_DEFAULT
) (
   input  logic clk,
   input  logic rstn,
   input  logic push,
   input  logic push_data,
   input  logic pop_ready,
   output logic valid,
   output logic data,
   output logic empty,
   output logic full,
   output logic overflow,
   input  logic overflow_clr
);

   localparam int CNT_W = sema_cnt_w(DEPTH);
   localparam int PTR_W = $clog2(DEPTH);

   logic [CNT_W-1:0] count_q, count_d;
   logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
   logic [DEPTH-1:0] mem_q;
   logic             overflow_q, overflow_d;
   logic             do_pop;
   logic             do_push;

   always_comb begin
      do_pop  = pop_ready && (count_q != '0);
      // A full queue still takes a token when the head leaves in the same cycle.
      do_push = push && ((count_q != CNT_W'(DEPTH)) || do_pop);

      count_d = count_q;
      case ({do_push, do_pop})
         2'b10:   count_d = count_q + CNT_W'(1);
         2'b01:   count_d = count_q - CNT_W'(1);
         default: count_d = count_q;
      endcase

      wr_ptr_d = do_push ? wr_ptr_q + PTR_W'(1) : wr_ptr_q;
      rd_ptr_d = do_pop  ? rd_ptr_q + PTR_W'(1) : rd_ptr_q;

      overflow_d = overflow_q;
      if (push && !do_push) begin
         overflow_d = 1'b1;
      end else if (overflow_clr) begin
         overflow_d = 1'b0;
      end
   end

   always_ff @(posedge clk or negedge rstn) begin
      if (!rstn) begin
         count_q    <= '0;
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         mem_q      <= '0;
         overflow_q <= 1'b0;
      end else begin
         count_q    <= count_d;
         wr_ptr_q   <= wr_ptr_d;
         rd_ptr_q   <= rd_ptr_d;
         overflow_q <= overflow_d;
         if (do_push) begin
            mem_q[wr_ptr_q] <= push_data;
         end
      end
   end

   assign valid    = (count_q != '0);
   assign empty    = (count_q == '0);
   assign full     = (count_q == CNT_W'(DEPTH));
   assign data     = mem_q[rd_ptr_q];
   assign overflow = overflow_q;

endmodule

// File: rtl/sema_mailbox.sv
// rtl/sema_mailbox.sv - two independent semaphore token queues between byte unit and bit unit
module sema_mailbox
   import sema_pkg::*;
#(
   parameter int DEPTH = SEMA_DEPTH_DEFAULT
) (
   input  logic       clk,
   input  logic       rstn,
   input  logic       byte_sema_write_i,
   input  logic       byte_sema_data_i,
   output logic       byte_sema_is_empty_o,
   output logic       bit_sema_valid_o,
   output logic       bit_sema_data_o,
   input  logic       bit_sema_ready_i,
   input  logic       bit_sema_write_i,
   input  logic       bit_sema_data_i,
   output logic       bit_sema_is_empty_o,
   output logic       byte_sema_valid_o,
   output logic       byte_sema_data_o,
   input  logic       byte_sema_ready_i,
   output logic [1:0] full_o,
   output logic [1:0] overflow_o,
   input  logic       overflow_clr_i
);

   sema_fifo #(.DEPTH(DEPTH)) u_fifo_b2b (
      .clk          (clk),
      .rstn         (rstn),
      .push         (byte_sema_write_i),
      .push_data    (byte_sema_data_i),
      .pop_ready    (bit_sema_ready_i),
      .valid        (bit_sema_valid_o),
      .data         (bit_sema_data_o),
      .empty        (byte_sema_is_empty_o),
      .full         (full_o[DIR_B2b]),
      .overflow     (overflow_o[DIR_B2b]),
      .overflow_clr (overflow_clr_i)
   );

   sema_fifo #(.DEPTH(DEPTH)) u_fifo_b2B (
      .clk          (clk),
      .rstn         (rstn),
      .push         (bit_sema_write_i),
      .push_data    (bit_sema_data_i),
      .pop_ready    (byte_sema_ready_i),
      .valid        (byte_sema_valid_o),
      .data         (byte_sema_data_o),
      .empty        (bit_sema_is_empty_o),
      .full         (full_o[DIR_b2B]),
      .overflow     (overflow_o[DIR_b2B]),
      .overflow_clr (overflow_clr_i)
   );

endmodule
